md_scheduler: RTL and testbench

- Sequences the multiply/divide resource in stage E.
- Accepts one MD operation per start pulse and holds busy for a fixed latency. Commits HI/LO at the end of that latency.
- Services mthi/mtlo writes.
- ATcontroller stalls D while start|busy is high on an MD instruction. cancel is driven by IntReq and squashes an operation whose start coincides with an exception.

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_core.sv | 62 ++++++
 rtl/md_scheduler.sv | 113 +++++++++++
 tb/tb_md_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared MD operation codes, FSM state type and op-class helpers for md_scheduler.
// The multiply-accumulate codes count as multiplies only when MD_MADD_EN is defined.
package md_pkg;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;
    localparam logic [3:0] MADD  = 4'd9;
    localparam logic [3:0] MADDU = 4'd10;
    localparam logic [3:0] MSUB  = 4'd11;
    localparam logic [3:0] MSUBU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MD_MADD_EN
        return (op == MULT) || (op == MULTU) || (op == MADD) ||
               (op == MADDU) || (op == MSUB) || (op == MSUBU);
`else
        return (op == MULT) || (op == MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational HI/LO result for a latched MD operation: signed/unsigned multiply and
// divide, plus multiply-accumulate when MD_MADD_EN is defined.
module md_core
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [63:0] res;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes; 0x8000_0000 / -1 falls out as quotient 0x8000_0000, remainder 0.
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    always_comb begin
        sq = abs_a / div_b;
        sr = abs_a % div_b;
        if (a[31] ^ b[31]) sq = ~sq + 32'd1;
        if (a[31])         sr = ~sr + 32'd1;
    end
    assign uq = a / ((b == 32'd0) ? 32'd1 : b);
    assign ur = a % ((b == 32'd0) ? 32'd1 : b);

    always_comb begin
        res = {hi, lo};
        case (op)
            MULT:  res = sprod;
            MULTU: res = uprod;
            DIV:   res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {sr, sq};
            DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {ur, uq};
`ifdef MD_MADD_EN
            MADD:  res = {hi, lo} + sprod;
            MADDU: res = {hi, lo} + uprod;
            MSUB:  res = {hi, lo} - sprod;
            MSUBU: res = {hi, lo} - uprod;
`endif
            default: res = {hi, lo};
        endcase
    end

    assign hi_next = res[63:32];
    assign lo_next = res[31:0];

endmodule

// File: rtl/md_scheduler.sv
// Stage-E multiply/divide sequencer: fixed-latency busy window, HI/LO commit, mthi/mtlo.
// Optional multiply-accumulate ops are enabled with MD_MADD_EN.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    md_state_t   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]  op_reg, op_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        done_reg, done_next;
    logic [31:0] core_hi;
    logic [31:0] core_lo;

    md_core u_core (
        .op      (op_reg),
        .a       (a_reg),
        .b       (b_reg),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .hi_next (core_hi),
        .lo_next (core_lo)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !cancel) begin
                    if (is_mul_op(MDOp) || is_div_op(MDOp)) begin
                        op_next    = MDOp;
                        a_next     = A;
                        b_next     = B;
                        cnt_next   = is_div_op(MDOp) ? CNT_W'(DIV_CYCLES - 1)
                                                     : CNT_W'(MULT_CYCLES - 1);
                        state_next = RUN;
                    end else if (MDOp == MTHI) begin
                        hi_next = A;
                    end else if (MDOp == MTLO) begin
                        lo_next = A;
                    end
                end
            end
            RUN: begin
                // start/cancel are deliberately ignored here: the in-flight op always completes.
                if (cnt_reg == '0) begin
                    hi_next    = core_hi;
                    lo_next    = core_lo;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= NONE;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed, table-driven bench for md_scheduler with hand-written multi-cycle sequences.
// Multiply-accumulate expectations are checked when MD_MADD_EN is defined.
module tb_md_scheduler;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDOp   (MDOp),
        .cancel (cancel),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start  = 1'b1;
        MDOp   = op;
        A      = a;
        B      = b;
        cancel = c;
        tick();
        start  = 1'b0;
        MDOp   = NONE;
        cancel = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int bad_busy;
        bad_busy = 0;
        drive(v.op, v.a, v.b, 1'b0);
        for (int i = 1; i <= v.n; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            tick();
        end
        chk({v.name, " busy window"}, 32'(bad_busy), 32'd0);
        chk({v.name, " busy end"}, {31'd0, busy}, 32'd0);
        chk({v.name, " done"}, {31'd0, done}, 32'd1);
        chk({v.name, " HI"}, HI, v.hi);
        chk({v.name, " LO"}, LO, v.lo);
        $display("op %0d a=%h b=%h -> HI=%h LO=%h", v.op, v.a, v.b, HI, LO);
        tick();
        chk({v.name, " done pulse"}, {31'd0, done}, 32'd0);
        hi_m = v.hi;
        lo_m = v.lo;
    endtask

    initial begin
        int seen_done;
        vecs[0] = '{"mult -3*7",   MULT,  32'hFFFF_FFFD, 32'd7,         5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{"multu big",   MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"multu max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3] = '{"mult -1*-1",  MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{"divu 100/7",  DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14};
        vecs[5] = '{"div -7/2",    DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6] = '{"div 7/-2",    DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{"div 5/0",     DIV,   32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF};
        vecs[8] = '{"divu 7/0",    DIVU,  32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF};
        vecs[9] = '{"div ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000};

        reset = 1'b1; start = 1'b0; MDOp = NONE; cancel = 1'b0; A = '0; B = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Cancelled start and cancelled mthi change nothing.
        drive(MULT, 32'd3, 32'd4, 1'b1);
        chk("cancel mult busy", {31'd0, busy}, 32'd0);
        tick();
        chk("cancel mult HI", HI, hi_m);
        chk("cancel mult LO", LO, lo_m);
        drive(MTHI, 32'h1234, 32'd0, 1'b1);
        chk("cancel mthi HI", HI, hi_m);
        drive(MTHI, 32'h1234, 32'd0, 1'b0);
        chk("mthi HI", HI, 32'h1234);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi done", {31'd0, done}, 32'd0);
        drive(MTLO, 32'h55, 32'd0, 1'b0);
        chk("mtlo LO", LO, 32'h55);
        chk("mtlo HI kept", HI, 32'h1234);
        drive(4'd15, 32'd9, 32'd9, 1'b0);
        chk("unknown op busy", {31'd0, busy}, 32'd0);
        chk("unknown op LO", LO, 32'h55);
        $display("mthi/mtlo/cancel sequence HI=%h LO=%h", HI, LO);

        // Hazard: starts and a cancel during a divide are ignored.
        drive(DIVU, 32'd100, 32'd7, 1'b0);
        drive(MULT, 32'd3, 32'd3, 1'b0);
        drive(MTLO, 32'd9, 32'd0, 1'b0);
        drive(NONE, 32'd0, 32'd0, 1'b1);
        chk("hazard busy c4", {31'd0, busy}, 32'd1);
        chk("hazard LO held", LO, 32'h55);
        for (int i = 4; i < 10; i++) tick();
        chk("hazard busy c10", {31'd0, busy}, 32'd1);
        tick();
        chk("hazard done", {31'd0, done}, 32'd1);
        chk("hazard busy c11", {31'd0, busy}, 32'd0);
        chk("hazard LO", LO, 32'd14);
        chk("hazard HI", HI, 32'd2);
        $display("hazard divu 100/7 -> HI=%h LO=%h", HI, LO);
        tick();

        // Reset in cycle 3 of a divide aborts with no commit.
        drive(DIV, 32'd100, 32'd7, 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
            tick();
        end
        chk("abort no done", 32'(seen_done), 32'd0);
        $display("reset mid-div -> HI=%h LO=%h", HI, LO);

        drive(MTLO, 32'd10, 32'd0, 1'b0);
`ifdef MD_MADD_EN
        begin
            vec_t mv;
            mv = '{"madd 10+2*3", MADD, 32'd2, 32'd3, 5, 32'd0, 32'd16};
            run_vec(mv);
            mv = '{"msub 16-1*20", MSUB, 32'd1, 32'd20, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
            run_vec(mv);
        end
`else
        drive(MADD, 32'd2, 32'd3, 1'b0);
        chk("madd off busy", {31'd0, busy}, 32'd0);
        tick();
        chk("madd off LO", LO, 32'd10);
        chk("madd off HI", HI, 32'd0);
        $display("madd disabled -> HI=%h LO=%h", HI, LO);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
